// File: rtl/perf_counter_unit.sv
// Performance counter unit: C event counters of W bits with sticky overflow flags,
// a snapshot shadow bank and a registered N-bit software read port.
module perf_counter_unit #(
    parameter int N         = 32,
    parameter int C         = 8,
    parameter int W         = 48,
    parameter int SATURATE  = 0,
    parameter int CYCLE_CH0 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 Freeze,
    input  logic [C-1:0]         Events,
    input  logic                 Clear,
    input  logic                 Snapshot,
    input  logic [$clog2(C)-1:0] RdSel,
    input  logic                 RdHi,
    output logic [N-1:0]         RdData,
    output logic [C-1:0]         Overflow,
    output logic                 OvfIrq
);

    localparam int SW = $clog2(C);
    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX_W = {W{1'b1}};

    logic [W-1:0] cnt_q [C];
    logic [W-1:0] cnt_d [C];
    logic [W-1:0] shd_q [C];
    logic [W-1:0] shd_d [C];
    logic [C-1:0] ovf_q;
    logic [C-1:0] ovf_d;
    logic [C-1:0] inc_s;
    logic [N-1:0] rd_q;
    logic [N-1:0] rd_d;
    logic         irq_q;
    logic         irq_d;
    logic [W-1:0] rd_word_s;
    logic [N-1:0] rd_hi_s;

    // Per-channel increment qualifier; channel 0 may count every enabled cycle
    always_comb begin
        inc_s = {C{1'b0}};
        for (int i = 0; i < C; i++) begin
            if (en && !Freeze) begin
                if (i == 0 && CYCLE_CH0 != 0) begin
                    inc_s[i] = 1'b1;
                end else begin
                    inc_s[i] = Events[i];
                end
            end else begin
                inc_s[i] = 1'b0;
            end
        end
    end

    // Live counter, overflow and shadow next-state
    always_comb begin
        for (int i = 0; i < C; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            shd_d[i] = shd_q[i];
            // Shadow always captures the pre-edge count, so Clear/increment never leak in
            if (Snapshot) begin
                shd_d[i] = cnt_q[i];
            end else begin
                shd_d[i] = shd_q[i];
            end
            if (Clear) begin
                cnt_d[i] = {W{1'b0}};
                ovf_d[i] = 1'b0;
            end else if (inc_s[i]) begin
                if (cnt_q[i] != MAX_W) begin
                    cnt_d[i] = cnt_q[i] + ONE_W;
                end else begin
                    ovf_d[i] = 1'b1;
                    if (SATURATE == 0) begin
                        cnt_d[i] = {W{1'b0}};
                    end else begin
                        cnt_d[i] = cnt_q[i];
                    end
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Read mux over the shadow bank; unmatched selects fall through to zero
    always_comb begin
        rd_word_s = {W{1'b0}};
        for (int i = 0; i < C; i++) begin
            if (RdSel == SW'(i)) begin
                rd_word_s = shd_q[i];
            end else begin
                rd_word_s = rd_word_s;
            end
        end
        rd_hi_s = {N{1'b0}};
        rd_hi_s[W-N-1:0] = rd_word_s[W-1:N];
        if (RdHi) begin
            rd_d = rd_hi_s;
        end else begin
            rd_d = rd_word_s[N-1:0];
        end
        irq_d = |ovf_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < C; i++) begin
                cnt_q[i] <= {W{1'b0}};
                shd_q[i] <= {W{1'b0}};
            end
            ovf_q <= {C{1'b0}};
            rd_q  <= {N{1'b0}};
            irq_q <= 1'b0;
        end else begin
            for (int i = 0; i < C; i++) begin
                cnt_q[i] <= cnt_d[i];
                shd_q[i] <= shd_d[i];
            end
            ovf_q <= ovf_d;
            rd_q  <= rd_d;
            irq_q <= irq_d;
        end
    end

    assign RdData   = rd_q;
    assign Overflow = ovf_q;
    assign OvfIrq   = irq_q;

    perf_counter_unit_chk #(
        .N (N),
        .C (C)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .Freeze   (Freeze),
        .Clear    (Clear),
        .RdData   (RdData),
        .Overflow (Overflow),
        .OvfIrq   (OvfIrq)
    );

endmodule

// Interface-level properties of the counter unit, observed from its ports.
module perf_counter_unit_chk #(
    parameter int N = 32,
    parameter int C = 8
) (
    input logic         clk,
    input logic         rst,
    input logic         en,
    input logic         Freeze,
    input logic         Clear,
    input logic [N-1:0] RdData,
    input logic [C-1:0] Overflow,
    input logic         OvfIrq
);

    a_reset_clears: assert property (@(posedge clk)
        !rst |=> (RdData == {N{1'b0}} && Overflow == {C{1'b0}} && OvfIrq == 1'b0));

    a_clear_ovf: assert property (@(posedge clk)
        (rst && Clear) |=> (Overflow == {C{1'b0}}));

    a_irq_follows: assert property (@(posedge clk)
        rst |=> (OvfIrq == $past(|Overflow)));

    a_ovf_hold: assert property (@(posedge clk)
        (rst && !Clear && !(en && !Freeze)) |=> (Overflow == $past(Overflow)));

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: three instances (wide wrap, narrow wrap, narrow saturate)
// compared every cycle against a per-instance behavioural model plus directed checks.
module tb_perf_counter_unit;

    logic        clk = 1'b0;
    logic        rst, en, freeze, clear, snap, rdhi;
    logic [7:0]  ev_a;
    logic [5:0]  ev_b;
    logic [2:0]  sel_a, sel_b;
    logic [31:0] rd_a;
    logic [7:0]  ovf_a;
    logic        irq_a;
    logic [7:0]  rd_b, rd_c;
    logic [5:0]  ovf_b, ovf_c;
    logic        irq_b, irq_c;

    int n_tests = 0;
    int n_fail  = 0;

    int cfg_c   [3] = '{8, 6, 6};
    int cfg_w   [3] = '{48, 12, 12};
    int cfg_n   [3] = '{32, 8, 8};
    int cfg_sat [3] = '{0, 0, 1};
    int cfg_cyc [3] = '{1, 0, 0};

    longint unsigned m_cnt [3][8];
    longint unsigned m_shd [3][8];
    bit              m_ovf [3][8];
    longint unsigned m_rd  [3];
    bit              m_irq [3];

    always #5 clk = ~clk;

    perf_counter_unit #(.N(32), .C(8), .W(48), .SATURATE(0), .CYCLE_CH0(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .Freeze(freeze), .Events(ev_a), .Clear(clear),
        .Snapshot(snap), .RdSel(sel_a), .RdHi(rdhi), .RdData(rd_a), .Overflow(ovf_a),
        .OvfIrq(irq_a));

    perf_counter_unit #(.N(8), .C(6), .W(12), .SATURATE(0), .CYCLE_CH0(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .Freeze(freeze), .Events(ev_b), .Clear(clear),
        .Snapshot(snap), .RdSel(sel_b), .RdHi(rdhi), .RdData(rd_b), .Overflow(ovf_b),
        .OvfIrq(irq_b));

    perf_counter_unit #(.N(8), .C(6), .W(12), .SATURATE(1), .CYCLE_CH0(0)) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .Freeze(freeze), .Events(ev_b), .Clear(clear),
        .Snapshot(snap), .RdSel(sel_b), .RdHi(rdhi), .RdData(rd_c), .Overflow(ovf_c),
        .OvfIrq(irq_c));

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour for instance d, using pre-edge state.
    task automatic model_edge(input int d, input logic [7:0] ev, input int sel);
        longint unsigned maxv;
        longint unsigned word;
        bit any;
        bit inc_m;
        maxv = (64'd1 << cfg_w[d]) - 64'd1;
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                m_cnt[d][i] = 0;
                m_shd[d][i] = 0;
                m_ovf[d][i] = 1'b0;
            end
            m_rd[d]  = 0;
            m_irq[d] = 1'b0;
        end else begin
            if (sel < cfg_c[d]) begin
                word = m_shd[d][sel];
                if (rdhi) m_rd[d] = word >> cfg_n[d];
                else      m_rd[d] = word % (64'd1 << cfg_n[d]);
            end else begin
                m_rd[d] = 0;
            end
            any = 1'b0;
            for (int i = 0; i < cfg_c[d]; i++) any = any | m_ovf[d][i];
            m_irq[d] = any;
            if (snap) begin
                for (int i = 0; i < cfg_c[d]; i++) m_shd[d][i] = m_cnt[d][i];
            end
            for (int i = 0; i < cfg_c[d]; i++) begin
                inc_m = en && !freeze && (ev[i] || (i == 0 && cfg_cyc[d] == 1));
                if (clear) begin
                    m_cnt[d][i] = 0;
                    m_ovf[d][i] = 1'b0;
                end else if (inc_m) begin
                    if (m_cnt[d][i] == maxv) begin
                        m_ovf[d][i] = 1'b1;
                        if (cfg_sat[d] == 0) m_cnt[d][i] = 0;
                    end else begin
                        m_cnt[d][i] = m_cnt[d][i] + 1;
                    end
                end
            end
        end
    endtask

    function automatic longint unsigned ovf_vec(input int d);
        longint unsigned v;
        v = 0;
        for (int i = 0; i < cfg_c[d]; i++) if (m_ovf[d][i]) v = v | (64'd1 << i);
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge(0, ev_a, int'(sel_a));
        model_edge(1, {2'b00, ev_b}, int'(sel_b));
        model_edge(2, {2'b00, ev_b}, int'(sel_b));
        #1;
        chk("rd_a",  rd_a,  m_rd[0]);
        chk("ovf_a", ovf_a, ovf_vec(0));
        chk("irq_a", irq_a, m_irq[0]);
        chk("rd_b",  rd_b,  m_rd[1]);
        chk("ovf_b", ovf_b, ovf_vec(1));
        chk("irq_b", irq_b, m_irq[1]);
        chk("rd_c",  rd_c,  m_rd[2]);
        chk("ovf_c", ovf_c, ovf_vec(2));
        chk("irq_c", irq_c, m_irq[2]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; freeze = 1'b0; clear = 1'b0; snap = 1'b0; rdhi = 1'b0;
        ev_a = 8'h00; ev_b = 6'h00; sel_a = 3'd0; sel_b = 3'd0;
        repeat (2) cycle();
        chk("rst_rd_a", rd_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_irq_b", irq_b, 0);

        // Cycle counting on channel 0
        rst = 1'b1; en = 1'b1;
        repeat (10) cycle();
        en = 1'b0; snap = 1'b1; cycle();
        snap = 1'b0; sel_a = 3'd0; cycle();
        chk("ch0_cycles", rd_a, 10);
        for (int k = 1; k < 8; k++) begin
            sel_a = 3'(k);
            cycle();
            chk("ch_idle", rd_a, 0);
        end

        // Freeze masks two of five pulses
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ev_a = 8'h08; ev_b = 6'h08; freeze = (k == 1 || k == 3);
            cycle();
            ev_a = 8'h00; ev_b = 6'h00; freeze = 1'b0;
            cycle();
        end
        en = 1'b0; snap = 1'b1; cycle();
        snap = 1'b0; sel_a = 3'd3; sel_b = 3'd3; cycle();
        chk("ch3_frz_a", rd_a, 3);
        chk("ch3_frz_b", rd_b, 3);

        // Wrap vs saturate on narrow channel 2
        en = 1'b1; ev_b = 6'h04;
        repeat (4095) cycle();
        chk("pre_wrap_ovf_b", ovf_b, 0);
        cycle();
        chk("wrap_ovf_b", ovf_b, 6'h04);
        chk("sat_ovf_c", ovf_c, 6'h04);
        chk("irq_lag_b", irq_b, 0);
        ev_b = 6'h00; cycle();
        chk("irq_b", irq_b, 1);
        chk("irq_c", irq_c, 1);
        en = 1'b0; snap = 1'b1; cycle();
        snap = 1'b0; sel_b = 3'd2; rdhi = 1'b0; cycle();
        chk("wrap_lo_b", rd_b, 0);
        chk("sat_lo_c", rd_c, 8'hFF);
        rdhi = 1'b1; cycle();
        chk("wrap_hi_b", rd_b, 0);
        chk("sat_hi_c", rd_c, 8'h0F);
        en = 1'b1; ev_b = 6'h04; cycle();
        en = 1'b0; ev_b = 6'h00; snap = 1'b1; cycle();
        snap = 1'b0; rdhi = 1'b0; cycle();
        chk("sat_hold_c", rd_c, 8'hFF);
        chk("wrap_next_b", rd_b, 1);

        // Split read: ch1 = 0x123 on narrow, ch4 = 7
        en = 1'b1;
        for (int k = 0; k < 291; k++) begin
            ev_a = (k < 7) ? 8'h12 : 8'h02;
            ev_b = (k < 7) ? 6'h12 : 6'h02;
            cycle();
        end
        ev_a = 8'h00; ev_b = 6'h00; en = 1'b0; snap = 1'b1; cycle();
        snap = 1'b0; sel_a = 3'd1; sel_b = 3'd1; rdhi = 1'b0; cycle();
        chk("lo_b", rd_b, 8'h23);
        chk("lo_a", rd_a, 291);
        rdhi = 1'b1; cycle();
        chk("hi_b", rd_b, 8'h01);
        chk("hi_a", rd_a, 0);

        // Clear and Snapshot together
        rdhi = 1'b0; clear = 1'b1; snap = 1'b1; cycle();
        clear = 1'b0; snap = 1'b0;
        chk("clr_ovf_b", ovf_b, 0);
        chk("clr_ovf_c", ovf_c, 0);
        chk("clr_irq_lag", irq_b, 1);
        sel_b = 3'd4; cycle();
        chk("clr_snap_b", rd_b, 7);
        chk("clr_irq_b", irq_b, 0);
        snap = 1'b1; cycle();
        snap = 1'b0; cycle();
        chk("clr_cnt_b", rd_b, 0);

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            rst    = ($urandom_range(199) != 0);
            en     = ($urandom_range(7) != 0);
            freeze = ($urandom_range(7) == 0);
            clear  = ($urandom_range(49) == 0);
            snap   = ($urandom_range(3) == 0);
            rdhi   = 1'($urandom_range(1));
            ev_a   = 8'($urandom());
            ev_b   = 6'($urandom());
            sel_a  = 3'($urandom());
            sel_b  = 3'($urandom());
            cycle();
        end

        // Reset mid-count with all strobes high
        rst = 1'b1; en = 1'b1; freeze = 1'b0; clear = 1'b0; snap = 1'b0; rdhi = 1'b0;
        ev_a = 8'hFF; ev_b = 6'h3F;
        repeat (5) cycle();
        rst = 1'b0; cycle();
        chk("mrst_rd_a", rd_a, 0);
        chk("mrst_ovf_a", ovf_a, 0);
        chk("mrst_irq_a", irq_a, 0);
        rst = 1'b1; snap = 1'b1; cycle();
        snap = 1'b0; sel_a = 3'd5; sel_b = 3'd5; cycle();
        chk("mrst_cnt_a", rd_a, 0);
        chk("mrst_cnt_b", rd_b, 0);
        snap = 1'b1; cycle();
        snap = 1'b0; cycle();
        chk("snap_pre_inc_a", rd_a, 2);
        chk("snap_pre_inc_b", rd_b, 2);
        sel_b = 3'd7; cycle();
        chk("oor7_b", rd_b, 0);
        sel_b = 3'd6; cycle();
        chk("oor6_c", rd_c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
